// File: rtl/sipo_rx_if.sv
// Serial-side inputs and parallel-side outputs of the sipo_rx receiver.
// The master drives the serial line; the slave is the receiver itself.
interface sipo_rx_if #(
    parameter int WIDTH = 8
);
    logic             serial_i;
    logic             bit_valid_i;
    logic             sof_i;
    logic [WIDTH-1:0] data_o;
    logic             data_valid_o;
    logic             busy_o;
    logic             frame_err_o;

    modport master (
        output serial_i, bit_valid_i, sof_i,
        input  data_o, data_valid_o, busy_o, frame_err_o
    );

    modport slave (
        input  serial_i, bit_valid_i, sof_i,
        output data_o, data_valid_o, busy_o, frame_err_o
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in/parallel-out receiver: assembles WIDTH qualified bits into a word,
// flags completion with data_valid_o and mid-frame restarts with frame_err_o.
module sipo_rx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    sipo_rx_if.slave   bus
);
    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_nxt;
    logic [CW-1:0]    cnt_q, cnt_nxt;
    logic [WIDTH-1:0] shift_q, shift_nxt;
    logic [WIDTH-1:0] data_q, data_nxt;
    logic             dv_q, dv_nxt;
    logic             fe_q, fe_nxt;
    logic             busy_q, busy_nxt;

    // Writes bit number idx of the frame into its output position.
    function automatic logic [WIDTH-1:0] place(input logic [WIDTH-1:0] word,
                                               input logic [CW-1:0]    idx,
                                               input logic             b);
        int               pos;
        logic [WIDTH-1:0] mask;
        pos  = LSB_FIRST ? int'(idx) : (WIDTH - 1) - int'(idx);
        mask = {{(WIDTH-1){1'b0}}, 1'b1} << pos;
        return b ? (word | mask) : (word & ~mask);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            fe_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            shift_q <= shift_nxt;
            data_q  <= data_nxt;
            dv_q    <= dv_nxt;
            fe_q    <= fe_nxt;
            busy_q  <= busy_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        shift_nxt = shift_q;
        data_nxt  = data_q;
        dv_nxt    = 1'b0;
        fe_nxt    = 1'b0;

        case (state_q)
            IDLE: begin
                // Bits without a start marker are stray and dropped silently.
                if (bus.bit_valid_i && bus.sof_i) begin
                    shift_nxt = place('0, '0, bus.serial_i);
                    cnt_nxt   = CW'(1);
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.bit_valid_i) begin
                    if (bus.sof_i) begin
                        // Restart wins even over a would-be final bit.
                        fe_nxt    = 1'b1;
                        shift_nxt = place('0, '0, bus.serial_i);
                        cnt_nxt   = CW'(1);
                    end else begin
                        shift_nxt = place(shift_q, cnt_q, bus.serial_i);
                        if (cnt_q == LAST_IDX) begin
                            data_nxt  = shift_nxt;
                            dv_nxt    = 1'b1;
                            cnt_nxt   = '0;
                            state_nxt = IDLE;
                        end else begin
                            cnt_nxt = cnt_q + CW'(1);
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        busy_nxt = (state_nxt == SHIFT);
    end

    assign bus.data_o       = data_q;
    assign bus.data_valid_o = dv_q;
    assign bus.busy_o       = busy_q;
    assign bus.frame_err_o  = fe_q;
endmodule

// File: doc/sipo_rx.md
# sipo_rx

Serial-in/parallel-out receiver; the receiving end of the team's 8-bit PISO serial link. It samples one bit per qualified clock and assembles `WIDTH` bits, LSB first by default. It then presents the completed word with a one-cycle valid pulse. It sits between the serial line (driven by a PISO transmitter) and the parallel consumer logic.

## Interface
- `WIDTH`, default 8: bits per frame; legal range 2..32.
- `LSB_FIRST`, default 1: 1 = first received bit is `data_o[0]`; 0 = first received bit is `data_o[WIDTH-1]`.

- `clk`  in  1  rising-edge clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high. Forces all state and outputs to reset values immediately.
- `serial_i`  in  1  serial data bit, sampled on the rising edge of `clk` when `bit_valid_i`=1.
- `bit_valid_i`  in  1  qualifies `serial_i` this cycle.
- `sof_i`  in  1  start of frame; only meaningful with `bit_valid_i`=1. Marks the sampled bit as bit 0.
- `data_o`  out  WIDTH  last completed word; holds until the next frame completes.
- `data_valid_o`  out  1  one-cycle pulse when `data_o` is updated.
- `busy_o`  out  1  high while a frame is partially received.
- `frame_err_o`  out  1  one-cycle pulse when a frame is aborted by a new `sof_i`.

## Operation
- Reset values:
  - `data_o`=0, `data_valid_o`=0, `busy_o`=0, `frame_err_o`=0.
  - Internal state IDLE, bit counter 0, shift register 0.
- State machine has two states: IDLE and SHIFT.
- IDLE:
  - `bit_valid_i`=1 and `sof_i`=1: store `serial_i` as bit 0, set counter to 1, go to SHIFT.
  - `bit_valid_i`=1 and `sof_i`=0: stray bit; ignore it and stay in IDLE (no error).
  - `sof_i`=1 with `bit_valid_i`=0: ignored in every state.
- SHIFT:
  - `bit_valid_i`=1 and `sof_i`=0: store `serial_i` as bit number counter, then increment counter.
    - If the stored bit was bit `WIDTH-1`: load the assembled word into `data_o`, pulse `data_valid_o`, clear counter, return to IDLE.
  - `bit_valid_i`=1 and `sof_i`=1: abort the current frame.
    - Pulse `frame_err_o`; the partial word is discarded and `data_o` is unchanged.
    - Store `serial_i` as bit 0 of the new frame, set counter to 1, stay in SHIFT.
    - Applies even when it coincides with what would have been bit `WIDTH-1`; no `data_valid_o` in that case.
  - `bit_valid_i`=0: hold all state; gaps between bits of any length are allowed.
- Bit placement: `LSB_FIRST`=1 puts bit k at `data_o[k]`; `LSB_FIRST`=0 puts bit k at `data_o[WIDTH-1-k]`.
- `busy_o` = (state == SHIFT), driven from a register.
- Counter width is clog2(WIDTH)+1 bits. It never exceeds `WIDTH-1` before clearing.

## Timing
- Bit sampling happens on the rising edge of `clk`.
- Latency: `data_o` and `data_valid_o` update at the same rising edge that samples the last bit. They are visible in the cycle after the last bit is presented.
- `data_valid_o` and `frame_err_o` are high for exactly one cycle per event and are never high together.
- Back-to-back frames are supported at full rate. A `sof_i` bit presented in the cycle right after the last bit of the previous frame starts a new frame with no lost cycle.
- `busy_o` rises at the edge sampling the `sof_i` bit. It falls at the edge that sets `data_valid_o`.
- Reset mid-frame: the partial frame is lost. No `data_valid_o` or `frame_err_o` is produced, and `data_o` returns to 0.
- Minimum frame time is `WIDTH` consecutive qualified cycles.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle during SHIFT after 3 bits -> all outputs 0 immediately. After release, a full frame of 0xA5 -> `data_o`=0xA5 with a single `data_valid_o` pulse.
- Directed LSB-first: send 0x55 (bits 1,0,1,0,…) on 8 consecutive cycles, `sof_i` on the first -> `data_o`=0x55 and `data_valid_o` one cycle after bit 7. Repeat with 0xFF and a `$urandom` byte.
- Gapped bits: send 0x3C with `bit_valid_i` low for 1–3 random cycles between bits -> `data_o`=0x3C, `busy_o` high throughout the frame, exactly one valid pulse.
- Back-to-back: frames 0x12 then 0x34 with no idle cycle -> two valid pulses 8 cycles apart with `data_o` 0x12 then 0x34.
- Abort: send 5 bits of 0xAA, then `sof_i` with a new frame 0x0F -> one `frame_err_o` pulse at the abort; `data_o` stays at its prior value until 0x0F completes. No valid pulse for the aborted frame.
- Stray bits and `LSB_FIRST`=0: bits without `sof_i` in IDLE -> no state change. With `LSB_FIRST`=0, send first-bit order 1,0,0,0,0,0,0,1 then 1,1,0,0,0,0,0,0 -> 0x81 then 0xC0.
